// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - FIFO-draining serial transmitter (8N1/8E1/8O1, one bit per clock)
module fifo_uart_tx #(
    parameter int Data_Width = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  EMPTY,
    input  logic [Data_Width-1:0] RD_DATA,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  R_INC,
    output logic                  TX_OUT,
    output logic                  BUSY
);
    localparam int CW = (Data_Width > 1) ? $clog2(Data_Width) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(Data_Width - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [Data_Width-1:0] shift_q, shift_d;
    logic                  par_en_q, par_en_d;
    logic                  par_bit_q, par_bit_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;

    // Pop only from IDLE or the stop cycle, so a new frame follows the stop bit with no gap.
    assign R_INC  = !RST && !EMPTY && ((state_q == S_IDLE) || (state_q == S_STOP));
    assign TX_OUT = tx_q;
    assign BUSY   = busy_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        tx_d      = tx_q;
        busy_d    = busy_q;

        case (state_q)
            S_IDLE, S_STOP: begin
                if (R_INC) begin
                    // Parity config is frozen here; later PAR_EN/PAR_TYP changes wait for the next frame.
                    state_d   = S_START;
                    shift_d   = RD_DATA;
                    par_en_d  = PAR_EN;
                    par_bit_d = (^RD_DATA) ^ PAR_TYP;
                    cnt_d     = '0;
                    tx_d      = 1'b0;
                    busy_d    = 1'b1;
                end else begin
                    state_d = S_IDLE;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            S_START: begin
                state_d = S_DATA;
                cnt_d   = '0;
                tx_d    = shift_q[0];
                shift_d = shift_q >> 1;
            end
            S_DATA: begin
                if (cnt_q == LAST_BIT) begin
                    if (par_en_q) begin
                        state_d = S_PARITY;
                        tx_d    = par_bit_q;
                    end else begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                end
            end
            S_PARITY: begin
                state_d = S_STOP;
                tx_d    = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb/tb_fifo_uart_tx.sv - directed self-checking bench for fifo_uart_tx
module tb_fifo_uart_tx;
    logic       CLK;
    logic       RST;
    logic       EMPTY;
    logic [7:0] RD_DATA;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       R_INC;
    logic       TX_OUT;
    logic       BUSY;

    int tests;
    int fails;
    int pops;

    logic [7:0] fq[$];
    logic       pop_s;

    fifo_uart_tx #(.Data_Width(8)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .EMPTY   (EMPTY),
        .RD_DATA (RD_DATA),
        .PAR_EN  (PAR_EN),
        .PAR_TYP (PAR_TYP),
        .R_INC   (R_INC),
        .TX_OUT  (TX_OUT),
        .BUSY    (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // FIFO read side: first-word fall-through, EMPTY/RD_DATA refreshed just after each edge.
    always @(posedge CLK) begin
        pop_s = R_INC;
        #1;
        if (pop_s && fq.size() > 0) begin
            void'(fq.pop_front());
            pops++;
        end
        EMPTY   = (fq.size() == 0);
        RD_DATA = (fq.size() == 0) ? 8'h00 : fq[0];
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit, got running, required finished");
        $fatal(1);
    end

    task automatic wait_pop(input string name);
        int k = 0;
        while (!R_INC && k < 20) begin
            @(negedge CLK);
            k++;
        end
        tests++;
        if (R_INC !== 1'b1) begin
            fails++;
            $display("FAIL %s_pop_timeout: R_INC got %b, required 1", name, R_INC);
        end
    endtask

    task automatic collect(input int n, input int toggle_at,
                           output logic [31:0] line, output logic [31:0] busy,
                           output logic [31:0] rinc);
        line = '0;
        busy = '0;
        rinc = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            line[i] = TX_OUT;
            busy[i] = BUSY;
            rinc[i] = R_INC;
            if (i == toggle_at) PAR_EN = !PAR_EN;
        end
    endtask

    task automatic test_reset();
        int k;
        RST = 1'b1;
        PAR_EN = 1'b0;
        PAR_TYP = 1'b0;
        fq.push_back(8'h00);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            tests++;
            if (TX_OUT !== 1'b1 || BUSY !== 1'b0 || R_INC !== 1'b0) begin
                fails++;
                $display("FAIL reset_hold: got tx=%b busy=%b rinc=%b, required tx=1 busy=0 rinc=0",
                         TX_OUT, BUSY, R_INC);
            end
        end
        RST = 1'b0;
        #1;
        tests++;
        if (R_INC !== 1'b1) begin
            fails++;
            $display("FAIL reset_release_rinc: got %b, required 1", R_INC);
        end
        @(negedge CLK);
        tests++;
        if (TX_OUT !== 1'b0 || BUSY !== 1'b1) begin
            fails++;
            $display("FAIL reset_first_start: got tx=%b busy=%b, required tx=0 busy=1", TX_OUT, BUSY);
        end
        k = 0;
        while (BUSY && k < 20) begin
            @(negedge CLK);
            k++;
        end
        tests++;
        if (BUSY !== 1'b0) begin
            fails++;
            $display("FAIL reset_drain: BUSY got %b, required 0", BUSY);
        end
    endtask

    task automatic test_single();
        logic [31:0] line, busy, rinc;
        int p0 = pops;
        fq.push_back(8'hA5);
        wait_pop("single");
        collect(12, -1, line, busy, rinc);
        tests++;
        if (line[11:0] !== 12'hF4A) begin
            fails++;
            $display("FAIL single_line: got %h, required f4a", line[11:0]);
        end
        tests++;
        if (busy[11:0] !== 12'h3FF) begin
            fails++;
            $display("FAIL single_busy: got %h, required 3ff", busy[11:0]);
        end
        tests++;
        if (rinc[11:0] !== 12'h000 || (pops - p0) != 1) begin
            fails++;
            $display("FAIL single_pops: got rinc=%h pops=%0d, required rinc=000 pops=1",
                     rinc[11:0], pops - p0);
        end
    endtask

    task automatic test_parity();
        logic [31:0] line, busy, rinc;
        logic [11:0] exp_line[2];
        exp_line[0] = 12'hD4A;
        exp_line[1] = 12'hF4A;
        for (int t = 0; t < 2; t++) begin
            PAR_EN = 1'b1;
            PAR_TYP = t[0];
            fq.push_back(8'hA5);
            wait_pop("parity");
            collect(12, -1, line, busy, rinc);
            tests++;
            if (line[11:0] !== exp_line[t]) begin
                fails++;
                $display("FAIL parity_line_typ%0d: got %h, required %h", t, line[11:0], exp_line[t]);
            end
            tests++;
            if (busy[11:0] !== 12'h7FF) begin
                fails++;
                $display("FAIL parity_busy_typ%0d: got %h, required 7ff", t, busy[11:0]);
            end
        end
        PAR_EN = 1'b0;
        PAR_TYP = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] line, busy, rinc;
        int p0 = pops;
        fq.push_back(8'h01);
        fq.push_back(8'hFF);
        fq.push_back(8'h80);
        wait_pop("b2b");
        collect(32, -1, line, busy, rinc);
        tests++;
        if (line !== 32'hF00FFA02) begin
            fails++;
            $display("FAIL b2b_line: got %h, required f00ffa02", line);
        end
        tests++;
        if (busy !== 32'h3FFFFFFF) begin
            fails++;
            $display("FAIL b2b_busy: got %h, required 3fffffff", busy);
        end
        tests++;
        if (rinc !== 32'h00080200) begin
            fails++;
            $display("FAIL b2b_rinc: got %h, required 00080200", rinc);
        end
        tests++;
        if ((pops - p0) != 3) begin
            fails++;
            $display("FAIL b2b_pops: got %0d, required 3", pops - p0);
        end
    endtask

    task automatic test_config_change();
        logic [31:0] line, busy, rinc;
        PAR_EN = 1'b0;
        fq.push_back(8'h3C);
        wait_pop("cfg_off");
        collect(12, 3, line, busy, rinc);
        tests++;
        if (line[11:0] !== 12'hE78 || busy[11:0] !== 12'h3FF) begin
            fails++;
            $display("FAIL cfg_latched_off: got line=%h busy=%h, required line=e78 busy=3ff",
                     line[11:0], busy[11:0]);
        end
        PAR_EN = 1'b1;
        PAR_TYP = 1'b0;
        fq.push_back(8'h3C);
        wait_pop("cfg_on");
        collect(12, 3, line, busy, rinc);
        tests++;
        if (line[11:0] !== 12'hC78 || busy[11:0] !== 12'h7FF) begin
            fails++;
            $display("FAIL cfg_latched_on: got line=%h busy=%h, required line=c78 busy=7ff",
                     line[11:0], busy[11:0]);
        end
        PAR_EN = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] line, busy, rinc;
        int p0;
        fq.push_back(8'h55);
        fq.push_back(8'h0F);
        wait_pop("midrst");
        collect(5, -1, line, busy, rinc);
        tests++;
        if (line[4:0] !== 5'b01010) begin
            fails++;
            $display("FAIL midrst_prefix: got %b, required 01010", line[4:0]);
        end
        RST = 1'b1;
        #1;
        tests++;
        if (TX_OUT !== 1'b1 || BUSY !== 1'b0 || R_INC !== 1'b0) begin
            fails++;
            $display("FAIL midrst_immediate: got tx=%b busy=%b rinc=%b, required tx=1 busy=0 rinc=0",
                     TX_OUT, BUSY, R_INC);
        end
        p0 = pops;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        wait_pop("midrst_next");
        collect(12, -1, line, busy, rinc);
        tests++;
        if (line[11:0] !== 12'hE1E || busy[11:0] !== 12'h3FF) begin
            fails++;
            $display("FAIL midrst_next_frame: got line=%h busy=%h, required line=e1e busy=3ff",
                     line[11:0], busy[11:0]);
        end
        tests++;
        if ((pops - p0) != 1) begin
            fails++;
            $display("FAIL midrst_pops: got %0d, required 1", pops - p0);
        end
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        pops    = 0;
        RST     = 1'b1;
        EMPTY   = 1'b1;
        RD_DATA = 8'h00;
        PAR_EN  = 1'b0;
        PAR_TYP = 1'b0;
        test_reset();
        test_single();
        test_parity();
        test_back_to_back();
        test_config_change();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
